// File: rtl/lumped_stamp_pkg.sv
// Shared types, constants and saturating Q16.16 arithmetic for the companion-model stamper.
package lumped_stamp_pkg;

  // Q16.16 fixed point: word width and fractional bits
  localparam int DATA_W = 32;
  localparam int FRAC   = 16;

  localparam logic [DATA_W-1:0] VAL_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] VAL_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Bounds of the 32-bit range, sign-extended to the full product width
  localparam logic signed [2*DATA_W-1:0] WIDE_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [2*DATA_W-1:0] WIDE_MIN = 64'shFFFF_FFFF_8000_0000;

  // Number of stamp slots walked per element: 4 matrix + 2 RHS
  localparam int NUM_SLOTS = 6;

  typedef enum logic [1:0] {
    EL_R   = 2'd0,
    EL_C   = 2'd1,
    EL_L   = 2'd2,
    EL_RSV = 2'd3
  } el_type_e;

  typedef enum logic {
    ST_MAT = 1'b0,
    ST_RHS = 1'b1
  } st_kind_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HIST = 2'd2,
    S_EMIT = 2'd3
  } state_e;

  // Full-width signed product, arithmetic shift back to Q16.16, clamp to 32 bits
  function automatic logic [DATA_W-1:0] sat_mul(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] ax;
    logic signed [2*DATA_W-1:0] bx;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [2*DATA_W-1:0] shr;
    ax   = {{DATA_W{a[DATA_W-1]}}, a};
    bx   = {{DATA_W{b[DATA_W-1]}}, b};
    prod = ax * bx;
    shr  = prod >>> FRAC;
    if (shr > WIDE_MAX)      sat_mul = VAL_MAX;
    else if (shr < WIDE_MIN) sat_mul = VAL_MIN;
    else                     sat_mul = shr[DATA_W-1:0];
  endfunction

  // Signed add with clamp on overflow
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1]) sat_add = s[DATA_W] ? VAL_MIN : VAL_MAX;
    else                          sat_add = s[DATA_W-1:0];
  endfunction

  // Negate; the most-negative value has no positive twin and clamps to max
  function automatic logic [DATA_W-1:0] sat_neg(input logic [DATA_W-1:0] a);
    if (a == VAL_MIN) sat_neg = VAL_MAX;
    else              sat_neg = {DATA_W{1'b0}} - a;
  endfunction

endpackage

// File: rtl/lumped_hist_ram.sv
// Inductor branch-current history store: 1R1W synchronous RAM, write-first on
// a same-address read so a read issued alongside a write sees the new value.
module lumped_hist_ram #(
  parameter int ID_W  = 6,
  parameter int VAL_W = 32
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ID_W-1:0]  waddr,
  input  logic [VAL_W-1:0] wdata,
  input  logic [ID_W-1:0]  raddr,
  output logic [VAL_W-1:0] rdata
);

  logic [VAL_W-1:0] mem [2**ID_W];

  // Write port plus registered read with same-address bypass
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/lumped_companion_stamper.sv
// Turns one lumped R/C/L record into backward-Euler MNA stamps.
// Handshakes (element in, stamp out): a beat transfers on a rising clock edge
// where valid and ready are both high; a producer holding valid keeps its
// payload stable until the transfer; el_ready is high only in IDLE.
// Pipeline: IDLE -> MUL (g*vprev, history read) -> HIST (ieq, history write)
// -> EMIT (walk the six stamp slots, skipping ones that reference ground,
// cancel, or carry a zero RHS) -> IDLE.
module lumped_companion_stamper
  import lumped_stamp_pkg::*;
#(
  parameter int NODE_W = 8,
  parameter int ID_W   = 6,
  parameter int VAL_W  = DATA_W   // arithmetic is Q16.16 on DATA_W bits
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              el_valid,
  output logic              el_ready,
  input  logic [1:0]        el_type,
  input  logic [ID_W-1:0]   el_id,
  input  logic              el_first,
  input  logic [NODE_W-1:0] el_p,
  input  logic [NODE_W-1:0] el_n,
  input  logic [VAL_W-1:0]  el_g,
  input  logic [VAL_W-1:0]  el_vprev,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_kind,
  output logic [NODE_W-1:0] st_row,
  output logic [NODE_W-1:0] st_col,
  output logic [VAL_W-1:0]  st_val,
  output logic [1:0]        dbg_state
);

  state_e             state;
  el_type_e           type_q;
  logic [ID_W-1:0]    id_q;
  logic               first_q;
  logic [NODE_W-1:0]  p_q;
  logic [NODE_W-1:0]  n_q;
  logic [VAL_W-1:0]   g_q;
  logic [VAL_W-1:0]   vprev_q;
  logic [VAL_W-1:0]   prod_q;
  logic [VAL_W-1:0]   ieq_q;
  logic [NUM_SLOTS-1:0] mask_q;
  logic [2:0]         slot_q;

  logic [VAL_W-1:0]   hist_rdata;
  logic [VAL_W-1:0]   ieq_next;
  logic               hist_we;

  logic [VAL_W-1:0]   neg_g;
  logic [VAL_W-1:0]   ld_ieq;
  logic [NUM_SLOTS-1:0] ld_mask;
  logic [2:0]         ld_slot;
  st_kind_e           ld_kind;
  logic [NODE_W-1:0]  ld_row;
  logic [NODE_W-1:0]  ld_col;
  logic [VAL_W-1:0]   ld_val;

  // Slots that produce a stamp; a self-loop (p==n) cancels everything
  function automatic logic [NUM_SLOTS-1:0] slot_mask(input logic [NODE_W-1:0] p,
                                                     input logic [NODE_W-1:0] n,
                                                     input logic [VAL_W-1:0]  ieq);
    logic pg;
    logic ng;
    logic iz;
    pg = (p == '0);
    ng = (n == '0);
    iz = (ieq == '0);
    slot_mask = '0;
    if (p != n) begin
      slot_mask[0] = !pg;
      slot_mask[1] = !ng;
      slot_mask[2] = !pg && !ng;
      slot_mask[3] = !pg && !ng;
      slot_mask[4] = !pg && !iz;
      slot_mask[5] = !ng && !iz;
    end
  endfunction

  // Lowest-numbered pending slot
  function automatic logic [2:0] first_slot(input logic [NUM_SLOTS-1:0] m);
    first_slot = 3'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (m[i]) first_slot = 3'(i);
    end
  endfunction

  assign el_ready  = (state == S_IDLE) && !rst;
  assign dbg_state = state;

  // Companion-model history current for the record in flight
  always_comb begin
    ieq_next = '0;
    case (type_q)
      EL_C:    ieq_next = prod_q;
      EL_L:    ieq_next = first_q ? '0 : sat_add(hist_rdata, prod_q);
      default: ieq_next = '0;
    endcase
  end

  // A reset landing on the HIST cycle must not leave a half-updated slot
  assign hist_we = (state == S_HIST) && (type_q == EL_L) && !rst;

  lumped_hist_ram #(
    .ID_W  (ID_W),
    .VAL_W (VAL_W)
  ) u_hist_ram (
    .clk   (clk),
    .we    (hist_we),
    .waddr (id_q),
    .wdata (ieq_next),
    .raddr (id_q),
    .rdata (hist_rdata)
  );

  // Next stamp to present: on leaving HIST the first live slot, in EMIT the
  // first live slot after the one just accepted
  always_comb begin
    neg_g   = sat_neg(g_q);
    ld_ieq  = (state == S_HIST) ? ieq_next : ieq_q;
    ld_mask = (state == S_HIST) ? slot_mask(p_q, n_q, ieq_next)
                                : (mask_q & ~(6'b000001 << slot_q));
    ld_slot = first_slot(ld_mask);
    ld_kind = ST_MAT;
    ld_row  = '0;
    ld_col  = '0;
    ld_val  = '0;
    case (ld_slot)
      3'd0: begin ld_row = p_q; ld_col = p_q; ld_val = g_q;   end
      3'd1: begin ld_row = n_q; ld_col = n_q; ld_val = g_q;   end
      3'd2: begin ld_row = p_q; ld_col = n_q; ld_val = neg_g; end
      3'd3: begin ld_row = n_q; ld_col = p_q; ld_val = neg_g; end
      3'd4: begin ld_kind = ST_RHS; ld_row = p_q; ld_val = ld_ieq; end
      default: begin ld_kind = ST_RHS; ld_row = n_q; ld_val = sat_neg(ld_ieq); end
    endcase
  end

  // Control FSM with registered stamp outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      type_q   <= EL_R;
      id_q     <= '0;
      first_q  <= 1'b0;
      p_q      <= '0;
      n_q      <= '0;
      g_q      <= '0;
      vprev_q  <= '0;
      prod_q   <= '0;
      ieq_q    <= '0;
      mask_q   <= '0;
      slot_q   <= '0;
      st_valid <= 1'b0;
      st_kind  <= 1'b0;
      st_row   <= '0;
      st_col   <= '0;
      st_val   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (el_valid) begin
            type_q  <= el_type_e'(el_type);
            id_q    <= el_id;
            first_q <= el_first;
            p_q     <= el_p;
            n_q     <= el_n;
            g_q     <= el_g;
            vprev_q <= el_vprev;
            // Reserved records are consumed and dropped
            if (el_type != EL_RSV) state <= S_MUL;
          end
        end
        S_MUL: begin
          prod_q <= sat_mul(g_q, vprev_q);
          state  <= S_HIST;
        end
        S_HIST: begin
          ieq_q <= ieq_next;
          if (ld_mask == '0) begin
            state <= S_IDLE;
          end else begin
            state    <= S_EMIT;
            mask_q   <= ld_mask;
            slot_q   <= ld_slot;
            st_valid <= 1'b1;
            st_kind  <= ld_kind;
            st_row   <= ld_row;
            st_col   <= ld_col;
            st_val   <= ld_val;
          end
        end
        S_EMIT: begin
          if (st_ready) begin
            if (ld_mask == '0) begin
              state    <= S_IDLE;
              mask_q   <= '0;
              st_valid <= 1'b0;
              st_kind  <= 1'b0;
              st_row   <= '0;
              st_col   <= '0;
              st_val   <= '0;
            end else begin
              mask_q  <= ld_mask;
              slot_q  <= ld_slot;
              st_kind <= ld_kind;
              st_row  <= ld_row;
              st_col  <= ld_col;
              st_val  <= ld_val;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lumped_companion_stamper.sv
// Bench for lumped_companion_stamper: reset checks, a table of element records
// with hand-computed stamps, plus latency, backpressure and mid-stream reset.
module tb_lumped_companion_stamper;

  localparam int NODE_W = 8;
  localparam int ID_W   = 6;
  localparam int VAL_W  = 32;
  localparam int SW     = 1 + 2*NODE_W + VAL_W;

  localparam logic [VAL_W-1:0] ONE  = 32'h0001_0000;
  localparam logic [VAL_W-1:0] MONE = 32'hFFFF_0000;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              el_valid = 1'b0;
  logic              el_ready;
  logic [1:0]        el_type = '0;
  logic [ID_W-1:0]   el_id = '0;
  logic              el_first = 1'b0;
  logic [NODE_W-1:0] el_p = '0;
  logic [NODE_W-1:0] el_n = '0;
  logic [VAL_W-1:0]  el_g = '0;
  logic [VAL_W-1:0]  el_vprev = '0;
  logic              st_valid;
  logic              st_ready = 1'b1;
  logic              st_kind;
  logic [NODE_W-1:0] st_row;
  logic [NODE_W-1:0] st_col;
  logic [VAL_W-1:0]  st_val;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  lumped_companion_stamper #(
    .NODE_W (NODE_W),
    .ID_W   (ID_W),
    .VAL_W  (VAL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .el_valid  (el_valid),
    .el_ready  (el_ready),
    .el_type   (el_type),
    .el_id     (el_id),
    .el_first  (el_first),
    .el_p      (el_p),
    .el_n      (el_n),
    .el_g      (el_g),
    .el_vprev  (el_vprev),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_kind   (st_kind),
    .st_row    (st_row),
    .st_col    (st_col),
    .st_val    (st_val),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [SW-1:0] exp_q[$];
  logic mon_en  = 1'b0;
  logic bp_rand = 1'b0;

  function automatic logic [SW-1:0] stp(input logic k, input logic [NODE_W-1:0] r,
                                        input logic [NODE_W-1:0] c, input logic [VAL_W-1:0] v);
    stp = {k, r, c, v};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, got, req);
    end
  endtask

  // Every accepted stamp is popped and compared against the expected queue
  always @(negedge clk) begin
    if (mon_en && st_valid && st_ready) begin
      logic [SW-1:0] got;
      logic [SW-1:0] e;
      got = {st_kind, st_row, st_col, st_val};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL stamp_unexpected: got kind=%0d row=%0d col=%0d val=%h, required none",
                 st_kind, st_row, st_col, st_val);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL stamp: got kind=%0d row=%0d col=%0d val=%h, required kind=%0d row=%0d col=%0d val=%h",
                   got[SW-1], got[SW-2 -: NODE_W], got[VAL_W +: NODE_W], got[VAL_W-1:0],
                   e[SW-1], e[SW-2 -: NODE_W], e[VAL_W +: NODE_W], e[VAL_W-1:0]);
        end
      end
    end
  end

  // Random downstream backpressure when enabled
  always begin
    @(posedge clk);
    #1;
    if (bp_rand) st_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]         t;
    logic [ID_W-1:0]    id;
    logic               f;
    logic [NODE_W-1:0]  p;
    logic [NODE_W-1:0]  n;
    logic [VAL_W-1:0]   g;
    logic [VAL_W-1:0]   vp;
    int                 ne;
    logic [5:0][SW-1:0] ex;
  } vec_t;

  vec_t vecs[16];
  int   nv = 0;

  task automatic add_vec(input logic [1:0] t, input logic [ID_W-1:0] id, input logic f,
                         input logic [NODE_W-1:0] p, input logic [NODE_W-1:0] n,
                         input logic [VAL_W-1:0] g, input logic [VAL_W-1:0] vp);
    vecs[nv].t  = t;
    vecs[nv].id = id;
    vecs[nv].f  = f;
    vecs[nv].p  = p;
    vecs[nv].n  = n;
    vecs[nv].g  = g;
    vecs[nv].vp = vp;
    vecs[nv].ne = 0;
    vecs[nv].ex = '0;
    nv++;
  endtask

  task automatic add_ex(input logic k, input logic [NODE_W-1:0] r,
                        input logic [NODE_W-1:0] c, input logic [VAL_W-1:0] v);
    vecs[nv-1].ex[vecs[nv-1].ne] = stp(k, r, c, v);
    vecs[nv-1].ne++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] t, input logic [ID_W-1:0] id, input logic f,
                      input logic [NODE_W-1:0] p, input logic [NODE_W-1:0] n,
                      input logic [VAL_W-1:0] g, input logic [VAL_W-1:0] vp);
    logic ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    el_valid = 1'b1; el_type = t; el_id = id; el_first = f;
    el_p = p; el_n = n; el_g = g; el_vprev = vp;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (el_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    el_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got el_ready=0 for 100 cycles, required 1");
    end
  endtask

  task automatic wait_done(input string nm);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (el_ready && exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_drain: got pending=%0d el_ready=%b, required pending=0 el_ready=1",
               nm, exp_q.size(), el_ready);
      exp_q.delete();
    end
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < nv; i++) begin
      for (int j = 0; j < vecs[i].ne; j++) exp_q.push_back(vecs[i].ex[j]);
      send(vecs[i].t, vecs[i].id, vecs[i].f, vecs[i].p, vecs[i].n, vecs[i].g, vecs[i].vp);
      wait_done($sformatf("%s_v%0d", nm, i));
    end
  endtask

  task automatic push_r12();
    exp_q.push_back(stp(1'b0, 8'd1, 8'd1, ONE));
    exp_q.push_back(stp(1'b0, 8'd2, 8'd2, ONE));
    exp_q.push_back(stp(1'b0, 8'd1, 8'd2, MONE));
    exp_q.push_back(stp(1'b0, 8'd2, 8'd1, MONE));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // R between 1 and 2, g=1.0
    add_vec(2'd0, 6'd0, 1'b0, 8'd1, 8'd2, ONE, 32'h0003_0000);
    add_ex(1'b0, 8'd1, 8'd1, ONE);  add_ex(1'b0, 8'd2, 8'd2, ONE);
    add_ex(1'b0, 8'd1, 8'd2, MONE); add_ex(1'b0, 8'd2, 8'd1, MONE);
    // C to ground: g=2.0 vprev=0.5 -> ieq=1.0
    add_vec(2'd1, 6'd0, 1'b0, 8'd3, 8'd0, 32'h0002_0000, 32'h0000_8000);
    add_ex(1'b0, 8'd3, 8'd3, 32'h0002_0000); add_ex(1'b1, 8'd3, 8'd0, ONE);
    // L id5 g=0.25: first step, no RHS
    add_vec(2'd2, 6'd5, 1'b1, 8'd1, 8'd2, 32'h0000_4000, 32'h0004_0000);
    add_ex(1'b0, 8'd1, 8'd1, 32'h0000_4000); add_ex(1'b0, 8'd2, 8'd2, 32'h0000_4000);
    add_ex(1'b0, 8'd1, 8'd2, 32'hFFFF_C000); add_ex(1'b0, 8'd2, 8'd1, 32'hFFFF_C000);
    // L id5 vprev=4.0 -> ieq=1.0
    add_vec(2'd2, 6'd5, 1'b0, 8'd1, 8'd2, 32'h0000_4000, 32'h0004_0000);
    add_ex(1'b0, 8'd1, 8'd1, 32'h0000_4000); add_ex(1'b0, 8'd2, 8'd2, 32'h0000_4000);
    add_ex(1'b0, 8'd1, 8'd2, 32'hFFFF_C000); add_ex(1'b0, 8'd2, 8'd1, 32'hFFFF_C000);
    add_ex(1'b1, 8'd1, 8'd0, ONE); add_ex(1'b1, 8'd2, 8'd0, MONE);
    // L id5 vprev=4.0 -> ieq=2.0
    add_vec(2'd2, 6'd5, 1'b0, 8'd1, 8'd2, 32'h0000_4000, 32'h0004_0000);
    add_ex(1'b0, 8'd1, 8'd1, 32'h0000_4000); add_ex(1'b0, 8'd2, 8'd2, 32'h0000_4000);
    add_ex(1'b0, 8'd1, 8'd2, 32'hFFFF_C000); add_ex(1'b0, 8'd2, 8'd1, 32'hFFFF_C000);
    add_ex(1'b1, 8'd1, 8'd0, 32'h0002_0000); add_ex(1'b1, 8'd2, 8'd0, 32'hFFFE_0000);
    // C with positive product overflow -> ieq saturates to max
    add_vec(2'd1, 6'd0, 1'b0, 8'd4, 8'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    add_ex(1'b0, 8'd4, 8'd4, 32'h7FFF_FFFF); add_ex(1'b1, 8'd4, 8'd0, 32'h7FFF_FFFF);
    // Reserved type: dropped
    add_vec(2'd3, 6'd0, 1'b0, 8'd1, 8'd2, ONE, ONE);
    // p==n: everything cancels
    add_vec(2'd0, 6'd0, 1'b0, 8'd5, 8'd5, ONE, ONE);
    // Most-negative g: -g clamps to max, ieq=0 so no RHS
    add_vec(2'd1, 6'd0, 1'b0, 8'd6, 8'd7, 32'h8000_0000, 32'h0000_0000);
    add_ex(1'b0, 8'd6, 8'd6, 32'h8000_0000); add_ex(1'b0, 8'd7, 8'd7, 32'h8000_0000);
    add_ex(1'b0, 8'd6, 8'd7, 32'h7FFF_FFFF); add_ex(1'b0, 8'd7, 8'd6, 32'h7FFF_FFFF);
    // C with p grounded, vprev=-2.0 -> ieq=-2.0, RHS(n)=+2.0
    add_vec(2'd1, 6'd0, 1'b0, 8'd0, 8'd2, ONE, 32'hFFFE_0000);
    add_ex(1'b0, 8'd2, 8'd2, ONE); add_ex(1'b1, 8'd2, 8'd0, 32'h0002_0000);
    // L id9 first, n grounded
    add_vec(2'd2, 6'd9, 1'b1, 8'd1, 8'd0, ONE, ONE);
    add_ex(1'b0, 8'd1, 8'd1, ONE);
    // L id5 again: history 2.0 + 1.0 = 3.0, untouched by id9
    add_vec(2'd2, 6'd5, 1'b0, 8'd1, 8'd2, 32'h0000_4000, 32'h0004_0000);
    add_ex(1'b0, 8'd1, 8'd1, 32'h0000_4000); add_ex(1'b0, 8'd2, 8'd2, 32'h0000_4000);
    add_ex(1'b0, 8'd1, 8'd2, 32'hFFFF_C000); add_ex(1'b0, 8'd2, 8'd1, 32'hFFFF_C000);
    add_ex(1'b1, 8'd1, 8'd0, 32'h0003_0000); add_ex(1'b1, 8'd2, 8'd0, 32'hFFFD_0000);
    // L id9: history 0 + (1.0 * -1.0) = -1.0
    add_vec(2'd2, 6'd9, 1'b0, 8'd1, 8'd0, ONE, MONE);
    add_ex(1'b0, 8'd1, 8'd1, ONE); add_ex(1'b1, 8'd1, 8'd0, MONE);
    // C with negative product overflow -> ieq saturates to min
    add_vec(2'd1, 6'd0, 1'b0, 8'd1, 8'd0, 32'h7FFF_FFFF, 32'h8000_0000);
    add_ex(1'b0, 8'd1, 8'd1, 32'h7FFF_FFFF); add_ex(1'b1, 8'd1, 8'd0, 32'h8000_0000);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_el_ready", {63'd0, el_ready}, 64'd0);
    chk("reset_st_valid", {63'd0, st_valid}, 64'd0);
    chk("reset_st_fields", {15'd0, st_kind, st_row, st_col, st_val}, 64'd0);
    chk("reset_state", {62'd0, dbg_state}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("post_reset_el_ready", {63'd0, el_ready}, 64'd1);

    // Latency: accept at edge 0, stamps visible after edges 2..5, ready after edge 6
    push_r12();
    @(posedge clk);
    #1;
    el_valid = 1'b1; el_type = 2'd0; el_id = '0; el_first = 1'b0;
    el_p = 8'd1; el_n = 8'd2; el_g = ONE; el_vprev = '0;
    @(posedge clk);
    #1;
    el_valid = 1'b0;
    for (int j = 0; j <= 6; j++) begin
      @(negedge clk);
      chk($sformatf("lat_st_valid_c%0d", j), {63'd0, st_valid}, {63'd0, (j >= 2 && j <= 5)});
      chk($sformatf("lat_el_ready_c%0d", j), {63'd0, el_ready}, {63'd0, (j == 6)});
    end
    wait_done("latency");

    // Table, no backpressure
    run_table("tab");

    // st_ready low for 3 cycles while slot 2 is presented
    push_r12();
    @(posedge clk);
    #1;
    el_valid = 1'b1; el_type = 2'd0; el_first = 1'b0;
    el_p = 8'd1; el_n = 8'd2; el_g = ONE; el_vprev = '0;
    @(posedge clk);
    #1;
    el_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    st_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("stall_valid_%0d", j), {63'd0, st_valid}, 64'd1);
      chk($sformatf("stall_hold_%0d", j), {15'd0, st_kind, st_row, st_col, st_val},
          {15'd0, stp(1'b0, 8'd1, 8'd2, MONE)});
    end
    @(posedge clk);
    #1;
    st_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_hold", {15'd0, st_kind, st_row, st_col, st_val},
        {15'd0, stp(1'b0, 8'd1, 8'd2, MONE)});
    wait_done("stall");

    // Table again under random backpressure
    @(posedge clk);
    #1;
    bp_rand = 1'b1;
    run_table("bp");
    bp_rand = 1'b0;
    @(posedge clk);
    #1;
    st_ready = 1'b1;

    // Reset while slot 1 of an R is presented
    exp_q.push_back(stp(1'b0, 8'd1, 8'd1, ONE));
    exp_q.push_back(stp(1'b0, 8'd2, 8'd2, ONE));
    @(posedge clk);
    #1;
    el_valid = 1'b1; el_type = 2'd0; el_first = 1'b0;
    el_p = 8'd1; el_n = 8'd2; el_g = ONE; el_vprev = '0;
    @(posedge clk);
    #1;
    el_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_slot1_valid", {63'd0, st_valid}, 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_st_valid", {63'd0, st_valid}, 64'd0);
    chk("rst_mid_el_ready", {63'd0, el_ready}, 64'd1);
    chk("rst_mid_pending", 64'(exp_q.size()), 64'd0);

    // Recovery: L first step after reset
    exp_q.push_back(stp(1'b0, 8'd1, 8'd1, 32'h0000_4000));
    exp_q.push_back(stp(1'b0, 8'd2, 8'd2, 32'h0000_4000));
    exp_q.push_back(stp(1'b0, 8'd1, 8'd2, 32'hFFFF_C000));
    exp_q.push_back(stp(1'b0, 8'd2, 8'd1, 32'hFFFF_C000));
    send(2'd2, 6'd5, 1'b1, 8'd1, 8'd2, 32'h0000_4000, 32'h0004_0000);
    wait_done("recover");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #400000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: got no completion within time limit, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
